// File: rtl/csel_adder_pipe.sv
// rtl/csel_adder_pipe.sv - pipelined carry-select adder, one BLOCK-bit slice per stage, valid/ready stream handshake
// Optional signed-overflow output is enabled with the CSEL_OVF_EN macro.
module csel_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    localparam int NSTG = WIDTH / BLOCK,
    localparam int OCCW = $clog2(NSTG + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [OCCW-1:0]  occ
`ifdef CSEL_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Stage k output registers. aw_q rotates right by BLOCK per stage, with the
    // fresh sum slice entering at the top, so after NSTG stages it is the full sum.
    logic             vld_q [NSTG];
    logic             cy_q  [NSTG];
    logic [WIDTH-1:0] aw_q  [NSTG];
    logic [WIDTH-1:0] bw_q  [NSTG];
`ifdef CSEL_OVF_EN
    logic             sa_q  [NSTG];
    logic             sb_q  [NSTG];
`endif

    // Stage inputs and the two candidate slice sums
    logic [WIDTH-1:0] st_a  [NSTG];
    logic [WIDTH-1:0] st_b  [NSTG];
    logic             st_c  [NSTG];
    logic             st_v  [NSTG];
    logic [BLOCK:0]   s0    [NSTG];
    logic [BLOCK:0]   s1    [NSTG];
    logic [BLOCK:0]   sel   [NSTG];

    logic             adv;
    logic             acc;
    logic             lve;
    logic [OCCW-1:0]  occ_q;

    function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                              input logic [BLOCK-1:0] y,
                                              input logic             ci);
        logic [BLOCK:0] r;
        logic           c;
        c = ci;
        for (int i = 0; i < BLOCK; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[BLOCK] = c;
        return r;
    endfunction

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign acc       = in_valid && adv;
    assign lve       = out_valid && out_ready;

    assign out_valid = vld_q[NSTG-1];
    assign sum       = aw_q[NSTG-1];
    assign cout      = cy_q[NSTG-1];
    assign occ       = occ_q;

    always_comb begin
        st_a[0] = a;
        st_b[0] = b;
        st_c[0] = cin;
        st_v[0] = in_valid;
        for (int k = 1; k < NSTG; k++) begin
            st_a[k] = aw_q[k-1];
            st_b[k] = bw_q[k-1];
            st_c[k] = cy_q[k-1];
            st_v[k] = vld_q[k-1];
        end
        // Both carry hypotheses are always computed; the incoming carry only picks one
        for (int k = 0; k < NSTG; k++) begin
            s0[k]  = ripple(st_a[k][BLOCK-1:0], st_b[k][BLOCK-1:0], 1'b0);
            s1[k]  = ripple(st_a[k][BLOCK-1:0], st_b[k][BLOCK-1:0], 1'b1);
            sel[k] = st_c[k] ? s1[k] : s0[k];
        end
    end

    // Data only loads with a valid beat, so bubbles leave the last result on sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                aw_q[k]  <= '0;
                bw_q[k]  <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_q[k] <= st_v[k];
                if (st_v[k]) begin
                    cy_q[k] <= sel[k][BLOCK];
                    aw_q[k] <= (st_a[k] >> BLOCK) |
                               (WIDTH'(sel[k][BLOCK-1:0]) << (WIDTH - BLOCK));
                    bw_q[k] <= st_b[k] >> BLOCK;
                end
            end
        end
    end

`ifdef CSEL_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++) begin
                sa_q[k] <= 1'b0;
                sb_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                if (st_v[k]) begin
                    sa_q[k] <= (k == 0) ? a[WIDTH-1] : sa_q[(k == 0) ? 0 : k-1];
                    sb_q[k] <= (k == 0) ? b[WIDTH-1] : sb_q[(k == 0) ? 0 : k-1];
                end
            end
        end
    end

    // Derived from registered state only, so it holds and resets along with sum
    assign ovf = (sa_q[NSTG-1] == sb_q[NSTG-1]) && (sum[WIDTH-1] != sa_q[NSTG-1]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (acc && !lve && occ_q != OCCW'(NSTG)) begin
            occ_q <= occ_q + OCCW'(1);
        end else if (lve && !acc && occ_q != '0) begin
            occ_q <= occ_q - OCCW'(1);
        end
    end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// tb/tb_csel_adder_pipe.sv - self-checking bench for csel_adder_pipe (WIDTH=16, BLOCK=4)
module tb_csel_adder_pipe;
    localparam int WIDTH = 16;
    localparam int BLOCK = 4;
    localparam int NSTG  = WIDTH / BLOCK;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        int               t;
    } beat_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             cin       = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic             cout;
    logic [WIDTH-1:0] sum;
    logic [2:0]       occ;
    logic             ovf_s;
`ifdef CSEL_OVF_EN
    logic             ovf;
    assign ovf_s = ovf;
`else
    assign ovf_s = 1'b0;
`endif

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cycle   = 0;
    int    extra   = 0;
    beat_t exp_q[$];
    beat_t exp_o[$];
    beat_t got_o[$];

    csel_adder_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .occ       (occ)
`ifdef CSEL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic beat_t ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic ci);
        beat_t  r;
        longint tot;
        longint stot;
        tot  = longint'(x) + longint'(y) + longint'(ci);
        stot = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        r.s  = WIDTH'(tot % (64'd1 << WIDTH));
        r.c  = (tot >= (64'd1 << WIDTH));
        r.v  = (stot > (2 ** (WIDTH - 1)) - 1) || (stot < -(2 ** (WIDTH - 1)));
        r.t  = 0;
        return r;
    endfunction

    // Called mid-cycle: records what the next rising edge will accept and retire
    task automatic book();
        beat_t g;
        if (out_valid && out_ready) begin
            g.s = sum; g.c = cout; g.v = ovf_s; g.t = cycle;
            if (exp_q.size() > 0) begin
                exp_o.push_back(exp_q.pop_front());
                got_o.push_back(g);
            end else begin
                extra++;
            end
        end
        if (in_valid && in_ready) begin
            g   = ref_add(a, b, cin);
            g.t = cycle;
            exp_q.push_back(g);
        end
    endtask

    task automatic clear();
        exp_q.delete(); exp_o.delete(); got_o.delete();
        extra = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1; book();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b req=0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b req=1", in_ready); end
        n_tests++; if (occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ got=%0d req=0", occ); end
        n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got=%h req=0000", sum); end
        n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b req=0", cout); end
`ifdef CSEL_OVF_EN
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b req=0", ovf); end
`endif
    endtask

    task automatic test_basic();
        logic [16:0] kreq [2];
        kreq[0] = 17'h1_0000;
        kreq[1] = 17'h0_0001;
        clear();
        @(negedge clk); in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0; out_ready = 1'b1; #1; book();
        @(negedge clk); a = 16'h0000; b = 16'h0000; cin = 1'b1; #1; book();
        drain(20);
        n_tests++; if (got_o.size() != 2) begin n_fail++; $display("FAIL basic_count got=%0d req=2", got_o.size()); end
        foreach (got_o[i]) begin
            n_tests++;
            if ({got_o[i].c, got_o[i].s} !== kreq[i]) begin
                n_fail++; $display("FAIL basic_result[%0d] got=%h req=%h", i, {got_o[i].c, got_o[i].s}, kreq[i]);
            end
            n_tests++;
            if (got_o[i].t - exp_o[i].t != NSTG) begin
                n_fail++; $display("FAIL basic_latency[%0d] got=%0d req=%0d", i, got_o[i].t - exp_o[i].t, NSTG);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        logic             vc [6];
        va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b0;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 1'b1;
        for (int i = 2; i < 6; i++) begin
            va[i] = WIDTH'($urandom); vb[i] = WIDTH'($urandom); vc[i] = 1'($urandom);
        end
        clear();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; #1; book();
        end
        drain(20);
        n_tests++; if (got_o.size() != 6) begin n_fail++; $display("FAIL b2b_count got=%0d req=6", got_o.size()); end
        n_tests++; if (got_o.size() > 0 && {got_o[0].c, got_o[0].s} !== 17'h0_5555) begin
            n_fail++; $display("FAIL b2b_first got=%h req=05555", {got_o[0].c, got_o[0].s});
        end
        n_tests++; if (got_o.size() > 1 && {got_o[1].c, got_o[1].s} !== 17'h1_FFFF) begin
            n_fail++; $display("FAIL b2b_second got=%h req=1ffff", {got_o[1].c, got_o[1].s});
        end
        foreach (got_o[i]) begin
            n_tests++;
            if (got_o[i].s !== exp_o[i].s || got_o[i].c !== exp_o[i].c) begin
                n_fail++; $display("FAIL b2b_result[%0d] got=%h/%b req=%h/%b", i, got_o[i].s, got_o[i].c, exp_o[i].s, exp_o[i].c);
            end
            n_tests++;
            if (got_o[i].t != got_o[0].t + i) begin
                n_fail++; $display("FAIL b2b_consecutive[%0d] got_cycle=%0d req_cycle=%0d", i, got_o[i].t, got_o[0].t + i);
            end
        end
    endtask

    task automatic test_random();
        int acc = 0;
        clear();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            #1;
            n_tests++;
            if (occ !== 3'(exp_q.size())) begin
                n_fail++; $display("FAIL rand_occ cycle=%0d got=%0d req=%0d", cycle, occ, exp_q.size());
            end
            n_tests++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++; $display("FAIL rand_in_ready cycle=%0d got=%b req=%b", cycle, in_ready, !out_valid || out_ready);
            end
            if (in_valid && in_ready) acc++;
            book();
        end
        drain(40);
        n_tests++; if (got_o.size() != acc) begin n_fail++; $display("FAIL rand_count got=%0d req=%0d", got_o.size(), acc); end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL rand_extra got=%0d req=0", extra); end
        foreach (got_o[i]) begin
            n_tests++;
            if (got_o[i].s !== exp_o[i].s || got_o[i].c !== exp_o[i].c) begin
                n_fail++; $display("FAIL rand_result[%0d] got=%h/%b req=%h/%b", i, got_o[i].s, got_o[i].c, exp_o[i].s, exp_o[i].c);
            end
`ifdef CSEL_OVF_EN
            n_tests++;
            if (got_o[i].v !== exp_o[i].v) begin
                n_fail++; $display("FAIL rand_ovf[%0d] got=%b req=%b", i, got_o[i].v, exp_o[i].v);
            end
`endif
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] va [5];
        logic [WIDTH-1:0] vb [5];
        int idx = 0;
        for (int i = 0; i < 5; i++) begin va[i] = WIDTH'($urandom); vb[i] = WIDTH'($urandom); end
        clear();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b0; cin = 1'b0;
            in_valid = (idx < 5);
            if (idx < 5) begin a = va[idx]; b = vb[idx]; end
            #1;
            if (in_valid && in_ready) idx++;
            book();
            if (c >= NSTG) begin
                n_tests++;
                if (sum !== exp_q[0].s || cout !== exp_q[0].c) begin
                    n_fail++; $display("FAIL stall_hold cycle=%0d got=%h/%b req=%h/%b", cycle, sum, cout, exp_q[0].s, exp_q[0].c);
                end
            end
        end
        n_tests++; if (idx != 4) begin n_fail++; $display("FAIL stall_accepted got=%0d req=4", idx); end
        n_tests++; if (occ !== 3'd4) begin n_fail++; $display("FAIL stall_occ got=%0d req=4", occ); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b req=0", in_ready); end
        @(negedge clk); out_ready = 1'b1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_fifth_accept got=%b req=1", in_ready); end
        book();
        drain(20);
        n_tests++; if (got_o.size() != 5) begin n_fail++; $display("FAIL stall_count got=%0d req=5", got_o.size()); end
        foreach (got_o[i]) begin
            n_tests++;
            if (got_o[i].s !== exp_o[i].s || got_o[i].c !== exp_o[i].c || (i < 5 && exp_o[i].s !== ref_add(va[i], vb[i], 1'b0).s)) begin
                n_fail++; $display("FAIL stall_result[%0d] got=%h/%b req=%h/%b", i, got_o[i].s, got_o[i].c, exp_o[i].s, exp_o[i].c);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); out_ready = 1'b0; in_valid = 1'b1;
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); #1; book();
        end
        @(negedge clk); in_valid = 1'b0; #1; book();
        n_tests++; if (occ !== 3'd3) begin n_fail++; $display("FAIL rstmid_occ_before got=%0d req=3", occ); end
        rst_n = 1'b0; #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b req=0", out_valid); end
        n_tests++; if (occ !== 3'd0) begin n_fail++; $display("FAIL rstmid_occ got=%0d req=0", occ); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
            book();
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_stale got=%0d req=0", seen); end
    endtask

`ifdef CSEL_OVF_EN
    task automatic test_ovf();
        logic [17:0] kreq [2];
        kreq[0] = {1'b1, 1'b0, 16'h8000};
        kreq[1] = {1'b1, 1'b1, 16'h0000};
        clear();
        @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b0; #1; book();
        @(negedge clk); a = 16'h8000; b = 16'h8000; #1; book();
        drain(20);
        n_tests++; if (got_o.size() != 2) begin n_fail++; $display("FAIL ovf_count got=%0d req=2", got_o.size()); end
        foreach (got_o[i]) begin
            n_tests++;
            if ({got_o[i].v, got_o[i].c, got_o[i].s} !== kreq[i]) begin
                n_fail++; $display("FAIL ovf_result[%0d] got=%h req=%h", i, {got_o[i].v, got_o[i].c, got_o[i].s}, kreq[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef CSEL_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cycle);
        $fatal(1);
    end

endmodule
